// File: rtl/vx_cache_core_rsp_merge.sv
// Packs per-bank core responses into one registered core response beat.
// Banks sharing the winner's tag merge into the same beat, one lane per tid.
module vx_cache_core_rsp_merge #(
    parameter int NUM_BANKS      = 4,
    parameter int NUM_REQUESTS   = 4,
    parameter int WORD_SIZE      = 4,
    parameter int CORE_TAG_WIDTH = 8,
    localparam int TIDW          = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1,
    localparam int DW            = WORD_SIZE * 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_BANKS-1:0]           per_bank_core_rsp_valid,
    input  logic [NUM_BANKS*TIDW-1:0]      per_bank_core_rsp_tid,
    input  logic [NUM_BANKS*DW-1:0]        per_bank_core_rsp_data,
    input  logic [NUM_BANKS*CORE_TAG_WIDTH-1:0] per_bank_core_rsp_tag,
    output logic [NUM_BANKS-1:0]           per_bank_core_rsp_ready,
    output logic [NUM_REQUESTS-1:0]        core_rsp_valid,
    output logic [NUM_REQUESTS*DW-1:0]     core_rsp_data,
    output logic [CORE_TAG_WIDTH-1:0]      core_rsp_tag,
    input  logic                           core_rsp_ready
);

    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic [NUM_REQUESTS-1:0]     r_valid;
    logic [NUM_REQUESTS*DW-1:0]  r_data;
    logic [CORE_TAG_WIDTH-1:0]   r_tag;

    logic [BW-1:0]               w_rr_ptr;
    logic                        w_stall;
    logic                        w_found;
    logic [BW-1:0]               w_winner;
    logic [CORE_TAG_WIDTH-1:0]   w_win_tag;
    logic [NUM_BANKS-1:0]        w_merge;
    logic [NUM_REQUESTS-1:0]     w_nxt_valid;
    logic [NUM_REQUESTS*DW-1:0]  w_nxt_data;

    // Bank visited at position i of the wrapped scan starting at the pointer.
    function automatic int scan_bank(input logic [BW-1:0] ptr, input int i);
        return (int'(ptr) + i) % NUM_BANKS;
    endfunction

    function automatic int lane_of(input int b);
        if (NUM_REQUESTS == 1) return 0;
        return int'(per_bank_core_rsp_tid[b*TIDW +: TIDW]);
    endfunction

    assign w_stall = (|r_valid) & ~core_rsp_ready;

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            int b;
            b = scan_bank(w_rr_ptr, i);
            if (!w_found && per_bank_core_rsp_valid[b]) begin
                w_found  = 1'b1;
                w_winner = BW'(b);
            end
        end
    end

    assign w_win_tag = per_bank_core_rsp_tag[int'(w_winner)*CORE_TAG_WIDTH +: CORE_TAG_WIDTH];

    // The winner always joins first; later banks join only on a tag match
    // and a lane that no earlier bank in the scan has claimed.
    always_comb begin
        w_merge     = '0;
        w_nxt_valid = '0;
        w_nxt_data  = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            int b;
            int lane;
            b    = scan_bank(w_rr_ptr, i);
            lane = lane_of(b);
            if (w_found && per_bank_core_rsp_valid[b]
                && (per_bank_core_rsp_tag[b*CORE_TAG_WIDTH +: CORE_TAG_WIDTH] == w_win_tag)
                && !w_nxt_valid[lane]) begin
                w_merge[b]                  = 1'b1;
                w_nxt_valid[lane]           = 1'b1;
                w_nxt_data[lane*DW +: DW]   = per_bank_core_rsp_data[b*DW +: DW];
            end
        end
    end

    // Handshake: a bank transfers on a cycle where its valid and ready are both
    // high; banks keep valid/tid/data/tag stable until then, and valid never
    // depends on ready. The core side transfers when any lane valid and
    // core_rsp_ready are high at the same edge.
    assign per_bank_core_rsp_ready = {NUM_BANKS{~w_stall & ~reset}} & w_merge;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_data  <= '0;
            r_tag   <= '0;
        end else if (!w_stall) begin
            r_valid <= w_nxt_valid;
            r_data  <= w_nxt_data;
            r_tag   <= w_found ? w_win_tag : '0;
        end
    end

    generate
        if (NUM_BANKS > 1) begin : g_rr
            logic [BW-1:0] r_rr_ptr;
            // Pointer width equals log2(NUM_BANKS), so the increment wraps.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_rr_ptr <= '0;
                end else if (!w_stall && w_found) begin
                    r_rr_ptr <= w_winner + BW'(1);
                end
            end
            assign w_rr_ptr = r_rr_ptr;
        end else begin : g_no_rr
            assign w_rr_ptr = '0;
        end
    endgenerate

    assign core_rsp_valid = r_valid;
    assign core_rsp_data  = r_data;
    assign core_rsp_tag   = r_tag;

endmodule

// File: tb/tb_vx_cache_core_rsp_merge.sv
// Scenario bench for vx_cache_core_rsp_merge: per-scenario tasks with inline
// ready checks and a beat scoreboard drained as the core accepts beats.
module tb_vx_cache_core_rsp_merge;
  localparam int NB   = 4;
  localparam int NR   = 4;
  localparam int TIDW = 2;
  localparam int DW   = 32;
  localparam int TW   = 8;
  localparam int W    = NR + NR * DW + TW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NB-1:0]      bank_valid;
  logic [NB*TIDW-1:0] bank_tid;
  logic [NB*DW-1:0]   bank_data;
  logic [NB*TW-1:0]   bank_tag;
  logic [NB-1:0]      bank_ready;
  logic [NR-1:0]      core_rsp_valid;
  logic [NR*DW-1:0]   core_rsp_data;
  logic [TW-1:0]      core_rsp_tag;
  logic               core_rsp_ready;

  logic [W-1:0] exp_q[$];
  int tests_run;
  int tests_failed;

  vx_cache_core_rsp_merge #(
    .NUM_BANKS(NB), .NUM_REQUESTS(NR), .WORD_SIZE(4), .CORE_TAG_WIDTH(TW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .per_bank_core_rsp_valid(bank_valid),
    .per_bank_core_rsp_tid(bank_tid),
    .per_bank_core_rsp_data(bank_data),
    .per_bank_core_rsp_tag(bank_tag),
    .per_bank_core_rsp_ready(bank_ready),
    .core_rsp_valid(core_rsp_valid),
    .core_rsp_data(core_rsp_data),
    .core_rsp_tag(core_rsp_tag),
    .core_rsp_ready(core_rsp_ready)
  );

  function automatic logic [NR*DW-1:0] lane_word(input int lane, input logic [DW-1:0] w);
    logic [NR*DW-1:0] r;
    r = '0;
    r[lane*DW +: DW] = w;
    return r;
  endfunction

  task automatic set_bank(input int b, input logic [TIDW-1:0] tid,
                          input logic [DW-1:0] d, input logic [TW-1:0] tag);
    bank_valid[b] = 1'b1;
    bank_tid[b*TIDW +: TIDW] = tid;
    bank_data[b*DW +: DW] = d;
    bank_tag[b*TW +: TW] = tag;
  endtask

  task automatic push_beat(input logic [NR-1:0] v, input logic [NR*DW-1:0] d, input logic [TW-1:0] t);
    exp_q.push_back({v, d, t});
  endtask

  // One clock: sample bank accepts and score any consumed beat at negedge,
  // then retire accepted banks just after the rising edge.
  task automatic tick(output logic [NB-1:0] acc);
    logic [W-1:0] got;
    logic [W-1:0] e;
    @(negedge clk);
    acc = bank_valid & bank_ready;
    if ((|core_rsp_valid) && core_rsp_ready) begin
      got = {core_rsp_valid, core_rsp_data, core_rsp_tag};
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL beat_unexpected got=%h", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          tests_failed++;
          $display("FAIL beat got=%h exp=%h", got, e);
        end
      end
    end
    @(posedge clk);
    #1;
    bank_valid = bank_valid & ~acc;
  endtask

  task automatic test_reset();
    set_bank(0, 2'd1, 32'h1234_5678, 8'h01);
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (core_rsp_valid !== 4'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", core_rsp_valid); end
    tests_run++;
    if (core_rsp_data !== '0) begin tests_failed++; $display("FAIL reset_data got=%h exp=0", core_rsp_data); end
    tests_run++;
    if (core_rsp_tag !== 8'h0) begin tests_failed++; $display("FAIL reset_tag got=%h exp=0", core_rsp_tag); end
    tests_run++;
    if (bank_ready !== 4'b0) begin tests_failed++; $display("FAIL reset_ready got=%b exp=0", bank_ready); end
    bank_valid = '0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [NB-1:0] acc;
    core_rsp_ready = 1'b1;
    set_bank(2, 2'd1, 32'hDEAD_BEEF, 8'h5A);
    push_beat(4'b0010, lane_word(1, 32'hDEAD_BEEF), 8'h5A);
    tick(acc);
    tests_run++;
    if (acc !== 4'b0100) begin tests_failed++; $display("FAIL single_ready got=%b exp=0100", acc); end
    tick(acc);
  endtask

  task automatic test_merge();
    logic [NB-1:0] acc;
    set_bank(0, 2'd0, 32'hA000_0000, 8'h11);
    set_bank(1, 2'd2, 32'hB111_1111, 8'h11);
    set_bank(3, 2'd3, 32'hD333_3333, 8'h11);
    push_beat(4'b1101, lane_word(0, 32'hA000_0000) | lane_word(2, 32'hB111_1111)
                       | lane_word(3, 32'hD333_3333), 8'h11);
    tick(acc);
    tests_run++;
    if (acc !== 4'b1011) begin tests_failed++; $display("FAIL merge_ready got=%b exp=1011", acc); end
    tick(acc);
  endtask

  // Pointer is 0 here; the second beat also drains the first in the same cycle.
  task automatic test_tid_conflict();
    logic [NB-1:0] acc;
    set_bank(0, 2'd2, 32'h0000_00C0, 8'h07);
    set_bank(1, 2'd2, 32'h0000_00C1, 8'h07);
    push_beat(4'b0100, lane_word(2, 32'h0000_00C0), 8'h07);
    tick(acc);
    tests_run++;
    if (acc !== 4'b0001) begin tests_failed++; $display("FAIL conflict_beat1 got=%b exp=0001", acc); end
    push_beat(4'b0100, lane_word(2, 32'h0000_00C1), 8'h07);
    tick(acc);
    tests_run++;
    if (acc !== 4'b0010) begin tests_failed++; $display("FAIL conflict_beat2 got=%b exp=0010", acc); end
    tick(acc);
  endtask

  task automatic test_tag_mismatch();
    logic [NB-1:0] acc;
    // Bank 3 alone moves the pointer from 2 back to 0.
    set_bank(3, 2'd0, 32'h3333_0000, 8'h22);
    push_beat(4'b0001, lane_word(0, 32'h3333_0000), 8'h22);
    tick(acc);
    tests_run++;
    if (acc !== 4'b1000) begin tests_failed++; $display("FAIL mismatch_pre got=%b exp=1000", acc); end
    tick(acc);
    set_bank(0, 2'd0, 32'hAAAA_0001, 8'h03);
    set_bank(2, 2'd1, 32'hBBBB_0002, 8'h04);
    push_beat(4'b0001, lane_word(0, 32'hAAAA_0001), 8'h03);
    tick(acc);
    tests_run++;
    if (acc !== 4'b0001) begin tests_failed++; $display("FAIL mismatch_first got=%b exp=0001", acc); end
    push_beat(4'b0010, lane_word(1, 32'hBBBB_0002), 8'h04);
    tick(acc);
    tests_run++;
    if (acc !== 4'b0100) begin tests_failed++; $display("FAIL mismatch_second got=%b exp=0100", acc); end
    // Pointer now 3: bank 0 must come before bank 2.
    set_bank(0, 2'd0, 32'hAAAA_0003, 8'h03);
    set_bank(2, 2'd1, 32'hBBBB_0004, 8'h04);
    push_beat(4'b0001, lane_word(0, 32'hAAAA_0003), 8'h03);
    tick(acc);
    tests_run++;
    if (acc !== 4'b0001) begin tests_failed++; $display("FAIL mismatch_wrap got=%b exp=0001", acc); end
    push_beat(4'b0010, lane_word(1, 32'hBBBB_0004), 8'h04);
    tick(acc);
    tests_run++;
    if (acc !== 4'b0100) begin tests_failed++; $display("FAIL mismatch_wrap2 got=%b exp=0100", acc); end
    tick(acc);
  endtask

  task automatic test_backpressure();
    logic [NB-1:0] acc;
    logic [W-1:0] hold;
    set_bank(0, 2'd3, 32'h0BAD_F00D, 8'h44);
    hold = {4'b1000, lane_word(3, 32'h0BAD_F00D), 8'h44};
    exp_q.push_back(hold);
    tick(acc);
    tests_run++;
    if (acc !== 4'b0001) begin tests_failed++; $display("FAIL bp_load got=%b exp=0001", acc); end
    core_rsp_ready = 1'b0;
    set_bank(1, 2'd0, 32'h1111_2222, 8'h55);
    for (int i = 0; i < 5; i++) begin
      tick(acc);
      tests_run++;
      if (acc !== 4'b0000) begin tests_failed++; $display("FAIL bp_ready cyc=%0d got=%b exp=0000", i, acc); end
      tests_run++;
      if ({core_rsp_valid, core_rsp_data, core_rsp_tag} !== hold) begin
        tests_failed++;
        $display("FAIL bp_hold cyc=%0d got=%h exp=%h", i, {core_rsp_valid, core_rsp_data, core_rsp_tag}, hold);
      end
    end
    core_rsp_ready = 1'b1;
    push_beat(4'b0001, lane_word(0, 32'h1111_2222), 8'h55);
    tick(acc);
    tests_run++;
    if (acc !== 4'b0010) begin tests_failed++; $display("FAIL bp_release got=%b exp=0010", acc); end
    tick(acc);
  endtask

  task automatic test_reset_mid();
    logic [NB-1:0] acc;
    set_bank(0, 2'd0, 32'h6666_6666, 8'h66);
    tick(acc);
    tests_run++;
    if (core_rsp_valid !== 4'b0001) begin tests_failed++; $display("FAIL rmid_pre got=%b exp=0001", core_rsp_valid); end
    set_bank(3, 2'd1, 32'h7777_7777, 8'h77);
    reset = 1'b1;
    #1;
    tests_run++;
    if ({core_rsp_valid, core_rsp_data, core_rsp_tag} !== '0) begin
      tests_failed++;
      $display("FAIL rmid_clear got=%h exp=0", {core_rsp_valid, core_rsp_data, core_rsp_tag});
    end
    tests_run++;
    if (bank_ready !== 4'b0) begin tests_failed++; $display("FAIL rmid_ready got=%b exp=0", bank_ready); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_beat(4'b0010, lane_word(1, 32'h7777_7777), 8'h77);
    tick(acc);
    tests_run++;
    if (acc !== 4'b1000) begin tests_failed++; $display("FAIL rmid_accept got=%b exp=1000", acc); end
    tick(acc);
    tick(acc);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    bank_valid = '0;
    bank_tid = '0;
    bank_data = '0;
    bank_tag = '0;
    core_rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_merge();
    test_tid_conflict();
    test_tag_mismatch();
    test_backpressure();
    test_reset_mid();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL beats_outstanding got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
